// File: rtl/pwm_generator_multi.sv
`default_nettype none
// ============================================================================
// Module      : pwm_generator_multi
// Description : Multi-channel PWM generator sharing one period counter.
//               Per-channel double-buffered duty words (applied only at a
//               period boundary), per-channel polarity, frame clock and
//               period-start strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_generator_multi #(
    parameter int CHANNELS = 4,
    parameter int DUTY_W   = 4,
    parameter int STEP     = 100,
    parameter int PERIOD   = 2000,
    parameter int CNT_W    = $clog2(PERIOD)
) (
    input  logic                         clk_1MHz,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [CHANNELS*DUTY_W-1:0]   duty_in,
    input  logic                         duty_load,
    input  logic [CHANNELS-1:0]          invert,
    output logic                         frame_clk,
    output logic                         period_start,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         load_ack
);

    // Threshold width is sized so duty*STEP can never overflow; the compare
    // width covers both the threshold and the counter.
    localparam int PROD_W = DUTY_W + $clog2(STEP) + 1;
    localparam int CMP_W  = (PROD_W > CNT_W) ? PROD_W : CNT_W;

    localparam logic [CNT_W-1:0]  c_last_cnt = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  c_half_cnt = CNT_W'(PERIOD / 2);
    localparam logic [PROD_W-1:0] c_step     = PROD_W'(STEP);

    logic [CNT_W-1:0]           r_cnt;
    logic [CHANNELS*DUTY_W-1:0] r_pending;
    logic [CHANNELS*DUTY_W-1:0] r_active;
    logic                       r_pending_valid;

    logic                       w_last;
    logic                       w_xfer_run;
    logic                       w_xfer_idle;
    logic [CHANNELS-1:0]        w_pwm_next;

    assign w_last      = (r_cnt == c_last_cnt);
    // Running: swap duties only on the last count so a period is never cut.
    assign w_xfer_run  = enable && w_last && (r_pending_valid || duty_load);
    // Stopped: no period in progress, so apply the cycle after capture.
    assign w_xfer_idle = !enable && r_pending_valid;

    // Per-channel compare; saturation falls out naturally since cnt < PERIOD.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [PROD_W-1:0] w_thresh;
        assign w_thresh      = PROD_W'(r_active[i*DUTY_W +: DUTY_W]) * c_step;
        assign w_pwm_next[i] = enable
                             ? ((CMP_W'(r_cnt) < CMP_W'(w_thresh)) ^ invert[i])
                             : invert[i];
    end

    // Shared period counter: held at zero while stopped, wraps at PERIOD-1.
    always_ff @(posedge clk_1MHz) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!enable || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Duty double buffer: capture into pending, transfer to active at boundary.
    always_ff @(posedge clk_1MHz) begin
        if (reset) begin
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_active        <= '0;
            load_ack        <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (duty_load) begin
                r_pending <= duty_in;
            end
            if (w_xfer_run) begin
                // A load landing on the last count bypasses the buffer.
                r_active        <= duty_load ? duty_in : r_pending;
                r_pending_valid <= 1'b0;
                load_ack        <= 1'b1;
            end else begin
                if (w_xfer_idle) begin
                    r_active        <= r_pending;
                    r_pending_valid <= 1'b0;
                    load_ack        <= 1'b1;
                end
                if (duty_load) begin
                    r_pending_valid <= 1'b1;
                end
            end
        end
    end

    // Registered outputs decoded from the current counter value.
    always_ff @(posedge clk_1MHz) begin
        if (reset) begin
            frame_clk    <= 1'b0;
            period_start <= 1'b0;
            pwm_out      <= '0;
        end else begin
            frame_clk    <= enable && (r_cnt < c_half_cnt);
            period_start <= enable && (r_cnt == '0);
            pwm_out      <= w_pwm_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_generator_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pwm_generator_multi
// Description : Directed, table-driven bench for pwm_generator_multi with a
//               second instance (STEP=200, DUTY_W=5) for saturation/reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_generator_multi;

    localparam int PER = 2000;

    logic        clk = 1'b0;
    logic        reset_a, reset_b, enable, d_load, sel;
    logic [19:0] d_duty;
    logic [3:0]  inv_a;
    logic [3:0]  pwm_a, pwm_b;
    logic        frame_a, frame_b, ps_a, ps_b, ack_a, ack_b;
    logic [3:0]  m_pwm;
    logic        m_frame, m_ps, m_ack;

    // 1 MHz nominal clock (period scaled to 10 ns)
    always #5 clk = ~clk;

    pwm_generator_multi u_dut (
        .clk_1MHz     (clk),
        .reset        (reset_a),
        .enable       (enable),
        .duty_in      (d_duty[15:0]),
        .duty_load    (d_load & ~sel),
        .invert       (inv_a),
        .frame_clk    (frame_a),
        .period_start (ps_a),
        .pwm_out      (pwm_a),
        .load_ack     (ack_a)
    );

    pwm_generator_multi #(.STEP(200), .DUTY_W(5)) u_sat (
        .clk_1MHz     (clk),
        .reset        (reset_b),
        .enable       (enable),
        .duty_in      (d_duty),
        .duty_load    (d_load & sel),
        .invert       (4'b0000),
        .frame_clk    (frame_b),
        .period_start (ps_b),
        .pwm_out      (pwm_b),
        .load_ack     (ack_b)
    );

    // Observation mux so one set of tasks can watch either instance
    assign m_pwm   = sel ? pwm_b   : pwm_a;
    assign m_frame = sel ? frame_b : frame_a;
    assign m_ps    = sel ? ps_b    : ps_a;
    assign m_ack   = sel ? ack_b   : ack_a;

    int checks = 0;
    int failures = 0;

    int         m_hi[4];
    int         m_edges[4];
    logic [3:0] m_first;
    int         m_fhi, m_psn, m_ackn, m_ack_k;

    typedef struct packed {
        logic [15:0]       duty;
        logic [3:0]        inv;
        logic [3:0][11:0]  hi;     // expected high cycles, [0] = ch0
        logic [3:0]        first;  // expected level at period start
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ps(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_ps && n < 2*PER + 4);
        if (!m_ps) check({name, " period_start timeout"}, 0, 1);
    endtask

    // Observe one full period starting at the current (period_start) sample;
    // optionally pulse duty_load at sample indices la0 / la1.
    task automatic measure(input int la0, input logic [19:0] v0,
                           input int la1, input logic [19:0] v1);
        logic [3:0] prev;
        for (int i = 0; i < 4; i++) begin
            m_hi[i]    = 0;
            m_edges[i] = 0;
        end
        m_fhi = 0; m_psn = 0; m_ackn = 0; m_ack_k = -1;
        m_first = m_pwm;
        prev    = m_pwm;
        for (int k = 0; k < PER; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_pwm[i]) m_hi[i]++;
                if (m_pwm[i] != prev[i]) m_edges[i]++;
            end
            prev = m_pwm;
            if (m_frame) m_fhi++;
            if (m_ps) m_psn++;
            if (m_ack) begin
                m_ackn++;
                m_ack_k = k;
            end
            if (k == la0) begin
                d_duty = v0; d_load = 1'b1;
            end else if (k == la1) begin
                d_duty = v1; d_load = 1'b1;
            end else begin
                d_load = 1'b0;
            end
            tick();
        end
        d_load = 1'b0;
    endtask

    // Hard stop if something wedges
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main directed sequence
    initial begin
        int a;
        int bad, fr, ps;
        vecs[0] = '{duty: 16'hA0F5, inv: 4'b0000,
                    hi: {12'd1000, 12'd0, 12'd1500, 12'd500}, first: 4'b1011};
        vecs[1] = '{duty: 16'h0753, inv: 4'b0010,
                    hi: {12'd0, 12'd700, 12'd1500, 12'd300}, first: 4'b0101};
        vecs[2] = '{duty: 16'h0000, inv: 4'b1111,
                    hi: {12'd2000, 12'd2000, 12'd2000, 12'd2000}, first: 4'b1111};
        vecs[3] = '{duty: 16'hE81F, inv: 4'b0000,
                    hi: {12'd1400, 12'd800, 12'd100, 12'd1500}, first: 4'b1111};

        reset_a = 1'b1; reset_b = 1'b1; enable = 1'b1; d_load = 1'b0;
        sel = 1'b0; d_duty = '0; inv_a = 4'b0000;
        repeat (3) tick();
        check("reset pwm_out", m_pwm, 0);
        check("reset frame_clk", m_frame, 0);
        check("reset period_start", m_ps, 0);
        check("reset load_ack", m_ack, 0);

        // Idle running: all duties zero
        reset_a = 1'b0; reset_b = 1'b0;
        wait_ps("idle");
        measure(-1, '0, -1, '0);
        check("idle pwm high", m_hi[0] + m_hi[1] + m_hi[2] + m_hi[3], 0);
        check("idle frame high", m_fhi, 1000);
        check("idle period_start count", m_psn, 1);
        check("idle next period_start", m_ps, 1);

        // Table: load mid-period, check the following full period
        for (int v = 0; v < 4; v++) begin
            inv_a = vecs[v].inv;
            measure(100, {4'h0, vecs[v].duty}, -1, '0);
            a = m_ackn;
            measure(-1, '0, -1, '0);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("v%0d ch%0d high", v, i), m_hi[i], int'(vecs[v].hi[i]));
                check($sformatf("v%0d ch%0d edges", v, i), m_edges[i],
                      (vecs[v].hi[i] > 0 && vecs[v].hi[i] < 2000) ? 1 : 0);
            end
            check($sformatf("v%0d first level", v), m_first, vecs[v].first);
            check($sformatf("v%0d frame high", v), m_fhi, 1000);
            check($sformatf("v%0d period_start count", v), m_psn, 1);
            check($sformatf("v%0d load_ack count", v), a + m_ackn, 1);
        end
        inv_a = 4'b0000;

        // Mid-period reload while ch0 high must not cut the current pulse
        measure(100, 20'h00005, -1, '0);
        measure(699, 20'h0000C, -1, '0);
        a = m_ackn;
        check("midload ch0 high this period", m_hi[0], 500);
        check("midload ch0 edges this period", m_edges[0], 1);
        check("midload ch0 starts high", m_first[0], 1);
        measure(-1, '0, -1, '0);
        check("midload ch0 high next period", m_hi[0], 1200);
        check("midload ack count", a + m_ackn, 1);

        // Load on the last count bypasses the buffer
        measure(1998, 20'h00007, -1, '0);
        check("lastcnt ack sample", m_ack_k, 1999);
        check("lastcnt ack count", m_ackn, 1);
        measure(-1, '0, -1, '0);
        check("lastcnt ch0 high", m_hi[0], 700);

        // Two loads in one period: last wins, one ack
        measure(299, 20'h00002, 799, 20'h00009);
        check("dblload ack count", m_ackn, 1);
        measure(-1, '0, -1, '0);
        check("dblload ch0 high", m_hi[0], 900);
        check("dblload no extra ack", m_ackn, 0);

        // Stopped: idle levels follow invert, no frame/strobe
        inv_a = 4'b0010;
        enable = 1'b0;
        tick(); tick();
        bad = 0; fr = 0; ps = 0;
        for (int k = 0; k < 10; k++) begin
            if (m_pwm != 4'b0010) bad++;
            if (m_frame) fr++;
            if (m_ps) ps++;
            tick();
        end
        check("disabled pwm mismatches", bad, 0);
        check("disabled frame high", fr, 0);
        check("disabled period_start", ps, 0);

        // Stopped load: capture, transfer next cycle, ack one cycle later
        d_duty = 20'h00050; d_load = 1'b1;
        tick();
        d_load = 1'b0;
        check("disabled ack s+1", m_ack, 0);
        tick();
        check("disabled ack s+2", m_ack, 1);
        tick();
        check("disabled ack s+3", m_ack, 0);

        // First enabled cycle decodes cnt=0
        enable = 1'b1;
        tick();
        check("reenable period_start", m_ps, 1);
        measure(-1, '0, -1, '0);
        check("reenable inv ch1 high", m_hi[1], 1500);
        check("reenable ch0 high", m_hi[0], 0);
        check("reenable ack count", m_ackn, 0);
        inv_a = 4'b0000;

        // Saturating instance: STEP=200, DUTY_W=5
        sel = 1'b1;
        wait_ps("sat");
        measure(100, {5'd31, 5'd10, 5'd9, 5'd15}, -1, '0);
        a = m_ackn;
        measure(-1, '0, -1, '0);
        check("sat ch0 high", m_hi[0], 2000);
        check("sat ch1 high", m_hi[1], 1800);
        check("sat ch2 high", m_hi[2], 2000);
        check("sat ch3 high", m_hi[3], 2000);
        check("sat ack count", a + m_ackn, 1);

        // Reset asserted on the edge where cnt=1234
        for (int k = 0; k < 1233; k++) tick();
        check("sat pre-reset pwm", m_pwm, 4'b1111);
        reset_b = 1'b1;
        tick();
        check("midreset pwm_out", m_pwm, 0);
        check("midreset frame_clk", m_frame, 0);
        check("midreset period_start", m_ps, 0);
        check("midreset load_ack", m_ack, 0);
        tick();
        reset_b = 1'b0;
        tick();
        check("post-reset period_start", m_ps, 1);
        check("post-reset frame_clk", m_frame, 1);
        check("post-reset pwm cleared", m_pwm, 0);
        tick();
        check("post-reset strobe single", m_ps, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
